mem_stage: RTL and testbench

//   MIPS memory stage. Sits directly downstream of the execute stage and consumes its
//   ALU result and control bits. Performs the data-memory load/store through a req/ack

---
 rtl/mips_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data toward memory,
// lane selection plus sign/zero extension for load data coming back.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Size 2'b11 falls through to the word defaults.
  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_size)
      MEM_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: req/ack data-memory access, write-back register, EX back-pressure.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic              ex_rf_enable,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [ADDR_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_rf_enable,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_misaligned
);
  import mips_pkg::*;

  mem_state_t r_state, w_next;

  logic              r_we, r_load, r_rf_en, r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic [REG_W-1:0]  r_dest;

  logic              r_wb_valid, r_wb_rf, r_exc;
  logic [REG_W-1:0]  r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_xfer, w_is_mem, w_trap, w_start, w_done;
  logic [ADDR_W-1:0] w_addr_al;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_load_data;

  assign w_xfer   = in_valid & in_ready & ~flush;
  assign w_is_mem = ex_load | ex_store;

`ifdef MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis  = (ex_size == MEM_HALF) ? ex_alu_result[0]
                : (ex_size[1] && ex_alu_result[1:0] != 2'b00);
  assign w_trap = w_is_mem & w_mis;
`else
  assign w_trap = 1'b0;
`endif

  // Low address bits are cleared for half/word; a no-op for aligned accesses.
  always_comb begin
    w_addr_al = ex_alu_result;
    if (ex_size == MEM_HALF) w_addr_al[0] = 1'b0;
    else if (ex_size[1])     w_addr_al[1:0] = 2'b00;
  end

  assign w_start = w_xfer & w_is_mem & ~w_trap;
  assign w_done  = (r_state == ACCESS) & mem_ack;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ACCESS;
      ACCESS:  if (mem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bundle latch (accept edge) and write-back register (retire edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_load     <= 1'b0;
      r_rf_en    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_dest     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rf    <= 1'b0;
      r_exc      <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc      <= 1'b0;
      if (w_start) begin
        r_we     <= ex_store & ~ex_load;
        r_load   <= ex_load;
        r_rf_en  <= ex_rf_enable;
        r_signed <= ex_signed;
        r_size   <= ex_size;
        r_addr   <= w_addr_al;
        r_sdata  <= ex_store_data;
        r_dest   <= ex_dest;
      end else if (w_xfer) begin
        r_wb_valid <= 1'b1;
        r_exc      <= w_trap;
        r_wb_rf    <= ex_rf_enable & ~w_trap;
        r_wb_dest  <= ex_dest;
        r_wb_data  <= DATA_W'(ex_alu_result);
      end
      if (w_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rf    <= r_load & r_rf_en;
        r_wb_dest  <= r_dest;
        if (r_load) r_wb_data <= w_load_data;
      end
    end
  end

  mem_lane_align u_align (
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_sdata),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // Enables are gated so nothing is presented to memory outside ACCESS.
  assign in_ready       = (r_state == IDLE);
  assign mem_req        = (r_state == ACCESS);
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_be         = (r_state == ACCESS) ? w_be : 4'b0000;
  assign mem_wdata      = w_wdata;
  assign wb_valid       = r_wb_valid;
  assign wb_rf_enable   = r_wb_rf;
  assign wb_dest        = r_wb_dest;
  assign wb_data        = r_wb_data;
  assign exc_misaligned = r_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences, random traffic
// checked against an arithmetic reference model. Honours MISALIGN_TRAP_EN.
module tb_mem_stage;

  logic        clk, reset, in_valid, in_ready, flush;
  logic        ex_load, ex_store, ex_rf_enable, ex_signed;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_dest;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_rf_enable, exc_misaligned;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  int n_chk = 0;
  int n_err = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ex_load(ex_load), .ex_store(ex_store), .ex_rf_enable(ex_rf_enable), .ex_size(ex_size),
    .ex_signed(ex_signed), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rf_enable(wb_rf_enable), .wb_dest(wb_dest), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        ld, st, rf, sgn;
    logic [1:0]  size;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  dest;
    int          waits;
    logic [31:0] exp_wb, exp_maddr, exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-addressed arithmetic on the spec's lane rules.
  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd1 && a % 2 != 0) || (size >= 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] m_addr(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd1) return a - (a % 2);
    if (size >= 2'd2) return a - (a % 4);
    return a;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    int lane = int'(m_addr(size, a) % 4);
    if (size == 2'd0) return 4'(1 << lane);
    if (size == 2'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    int lane = int'(m_addr(size, a) % 4);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rd >> (8 * lane)) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rd >> (8 * lane)) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic trap_of(input vec_t v);
`ifdef MISALIGN_TRAP_EN
    return (v.ld | v.st) & m_mis(v.size, v.addr);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one bundle from IDLE and follow it to its write-back pulse.
  task automatic run(input vec_t v, input string tag);
    int lat, busy;
    logic trap;
    trap = trap_of(v);
    ex_load = v.ld; ex_store = v.st; ex_rf_enable = v.rf; ex_signed = v.sgn;
    ex_size = v.size; ex_alu_result = v.addr; ex_store_data = v.sdata; ex_dest = v.dest;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ex_alu_result = $urandom;
    lat = 1;
    busy = 0;
    if ((v.ld | v.st) && !trap) begin
      chk({tag, ".req"}, mem_req, 1'b1);
      chk({tag, ".we"}, mem_we, v.st & ~v.ld);
      chk({tag, ".addr"}, mem_addr, v.exp_maddr);
      chk({tag, ".be"}, mem_be, v.exp_be);
      if (v.st && !v.ld) chk({tag, ".wdata"}, mem_wdata, v.exp_wdata);
      for (int i = 0; i < v.waits; i++) begin
        if (!in_ready) busy++;
        step();
        lat++;
      end
      chk({tag, ".hold_addr"}, mem_addr, v.exp_maddr);
      if (!in_ready) busy++;
      mem_ack = 1'b1;
      mem_rdata = v.rdata;
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      lat++;
      chk({tag, ".busy"}, busy, v.waits + 1);
      chk({tag, ".lat"}, lat, v.waits + 2);
      chk({tag, ".req_drop"}, mem_req, 1'b0);
      chk({tag, ".wbv"}, wb_valid, 1'b1);
      chk({tag, ".rf"}, wb_rf_enable, v.ld & v.rf);
      if (v.ld) begin
        chk({tag, ".data"}, wb_data, v.exp_wb);
        chk({tag, ".dest"}, wb_dest, v.dest);
      end
    end else begin
      chk({tag, ".noreq"}, mem_req, 1'b0);
      chk({tag, ".wbv"}, wb_valid, 1'b1);
      chk({tag, ".data"}, wb_data, v.exp_wb);
      chk({tag, ".rf"}, wb_rf_enable, v.rf & ~trap);
      chk({tag, ".dest"}, wb_dest, v.dest);
    end
    chk({tag, ".exc"}, exc_misaligned, trap);
  endtask

  function automatic vec_t mk(input logic ld, st, rf, sgn, input logic [1:0] size,
                              input logic [31:0] addr, sdata, rdata, input logic [4:0] dest,
                              input int waits, input logic [31:0] exp_wb, exp_maddr,
                              exp_wdata, input logic [3:0] exp_be);
    vec_t v;
    v.ld = ld; v.st = st; v.rf = rf; v.sgn = sgn; v.size = size; v.addr = addr;
    v.sdata = sdata; v.rdata = rdata; v.dest = dest; v.waits = waits; v.exp_wb = exp_wb;
    v.exp_maddr = exp_maddr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
    return v;
  endfunction

  vec_t tbl[$];
  logic [31:0] held;

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_rf_enable = 1'b0; ex_signed = 1'b0; ex_size = 2'b00; ex_alu_result = '0;
    ex_store_data = '0; ex_dest = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_be", mem_be, 4'b0000);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.wb_valid", wb_valid, 1'b0);
    chk("rst.wb_data", wb_data, 32'h0);
    chk("rst.exc", exc_misaligned, 1'b0);

    //             ld   st   rf   sgn  size   addr          sdata         rdata        dst wt exp_wb        maddr         wdata         be
    tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd0,32'h0000_1234,32'h0,        32'h0,        5,0,32'h0000_1234,32'h0,        32'h0,        4'h0));
    tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,2'd0,32'h0000_0103,32'h0000_00AB,32'h0,        6,3,32'h0,        32'h0000_0103,32'hABAB_ABAB,4'b1000));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b1,2'd0,32'h0000_0102,32'h0,        32'h0080_0000,7,1,32'hFFFF_FF80,32'h0000_0102,32'h0,        4'b0100));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,2'd0,32'h0000_0102,32'h0,        32'h0080_0000,7,0,32'h0000_0080,32'h0000_0102,32'h0,        4'b0100));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,2'd1,32'h0000_0202,32'h0,        32'h8001_0000,8,0,32'h0000_8001,32'h0000_0202,32'h0,        4'b1100));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b1,2'd1,32'h0000_0200,32'h0,        32'h1234_FFFE,9,2,32'hFFFF_FFFE,32'h0000_0200,32'h0,        4'b0011));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,2'd1,32'h0000_0012,32'h5566_7788,32'h0,        1,1,32'h0,        32'h0000_0012,32'h7788_7788,4'b1100));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,2'd3,32'h0000_0040,32'hDEAD_BEEF,32'h0,        2,0,32'h0,        32'h0000_0040,32'hDEAD_BEEF,4'b1111));
    tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,2'd2,32'h0000_0044,32'h0,        32'hCAFE_F00D,3,0,32'hCAFE_F00D,32'h0000_0044,32'h0,        4'b1111));
`ifdef MISALIGN_TRAP_EN
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,2'd2,32'h0000_0301,32'h0,        32'h0,        4,0,32'h0000_0301,32'h0,        32'h0,        4'h0));
`else
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,2'd2,32'h0000_0301,32'h0,        32'h1122_3344,4,0,32'h1122_3344,32'h0000_0300,32'h0,        4'b1111));
`endif
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Write-back outputs hold between pulses; a stray ack in IDLE does nothing.
    held = wb_data;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle.wbv", wb_valid, 1'b0);
    chk("idle.hold", wb_data, held);
    chk("idle.ready", in_ready, 1'b1);

    // Flushed bundles are dropped.
    ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2; ex_alu_result = 32'h80;
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush.req", mem_req, 1'b0);
    chk("flush.wbv", wb_valid, 1'b0);
    chk("flush.ready", in_ready, 1'b1);

    // Reset while an access is outstanding abandons it.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstacc.req_before", mem_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstacc.req", mem_req, 1'b0);
    chk("rstacc.ready", in_ready, 1'b1);
    chk("rstacc.wbv", wb_valid, 1'b0);
    step();
    chk("rstacc.req_after", mem_req, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int kind = int'($urandom_range(0, 2));
      v.ld = (kind == 1); v.st = (kind == 2);
      v.rf = 1'($urandom); v.sgn = 1'($urandom); v.size = 2'($urandom);
      v.addr = $urandom & 32'h0000_0FFF; v.sdata = $urandom; v.rdata = $urandom;
      v.dest = 5'($urandom); v.waits = int'($urandom_range(0, 3));
      v.exp_maddr = m_addr(v.size, v.addr);
      v.exp_be = m_be(v.size, v.addr);
      v.exp_wdata = m_wdata(v.size, v.sdata);
      if (!(v.ld | v.st)) v.exp_wb = v.addr;
      else if (trap_of(v)) v.exp_wb = v.addr;
      else v.exp_wb = m_load(v.size, v.sgn, v.addr, v.rdata);
      run(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
